// File: rtl/random_checker_if.sv
// rtl/random_checker_if.sv - sample stream and status bundle for random_checker
interface random_checker_if;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] sample_count;

  modport master (
    output in_valid, in_data,
    input  locked, err_pulse, err_count, sample_count
  );

  modport slave (
    input  in_valid, in_data,
    output locked, err_pulse, err_count, sample_count
  );
endinterface

// File: rtl/random_checker.sv
// rtl/random_checker.sv - locks onto a 4-bit random sequence and counts mismatches
// Optional statistics counters enabled by macro RANDOM_CHECKER_STATS_EN.
module random_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  random_checker_if.slave bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state_q, state_d;
  logic       seed_valid_q, seed_valid_d;
  logic [3:0] seed_q, seed_d;
  logic [3:0] match_run_q, match_run_d;
  logic [3:0] miss_run_q, miss_run_d;
  logic [3:0] expected_q, expected_d;
  logic       err_pulse_q, err_pulse_d;

  function automatic logic [3:0] nxt(input logic [3:0] c);
    return {c[3] ^ c[2], c[2] ^ c[1], c[1] ^ c[0], c[0] ^ c[3] ^ c[2]};
  endfunction

  always_comb begin
    state_d      = state_q;
    seed_valid_d = seed_valid_q;
    seed_d       = seed_q;
    match_run_d  = match_run_q;
    miss_run_d   = miss_run_q;
    expected_d   = expected_q;
    err_pulse_d  = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.in_data == 4'b0000) begin
            seed_valid_d = 1'b0;
            match_run_d  = 4'd0;
          end else begin
            seed_valid_d = 1'b1;
            seed_d       = bus.in_data;
            if (seed_valid_q && bus.in_data == nxt(seed_q)) begin
              match_run_d = match_run_q + 4'd1;
            end else begin
              match_run_d = 4'd1;
            end
            if (match_run_d == 4'(LOCK_CNT)) begin
              state_d    = LOCKED;
              expected_d = nxt(bus.in_data);
              miss_run_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          // The reference keeps free-running so a bad sample cannot reseed it.
          expected_d = nxt(expected_q);
          if (bus.in_data == expected_q) begin
            miss_run_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            miss_run_d  = miss_run_q + 4'd1;
            if (miss_run_d == 4'(LOSS_CNT)) begin
              state_d      = HUNT;
              seed_valid_d = 1'b0;
              match_run_d  = 4'd0;
              miss_run_d   = 4'd0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      seed_valid_q <= 1'b0;
      seed_q       <= 4'd0;
      match_run_q  <= 4'd0;
      miss_run_q   <= 4'd0;
      expected_q   <= 4'd0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_valid_q <= seed_valid_d;
      seed_q       <= seed_d;
      match_run_q  <= match_run_d;
      miss_run_q   <= miss_run_d;
      expected_q   <= expected_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_pulse = err_pulse_q;

`ifdef RANDOM_CHECKER_STATS_EN
  logic [15:0] err_count_q, err_count_d;
  logic [15:0] sample_count_q, sample_count_d;
  logic        inc_samp, inc_err;

  assign inc_samp = bus.in_valid && (state_q == LOCKED);
  assign inc_err  = inc_samp && (bus.in_data != expected_q);

  always_comb begin
    err_count_d    = err_count_q;
    sample_count_d = sample_count_q;
    if (inc_err && err_count_q != 16'hFFFF) begin
      err_count_d = err_count_q + 16'd1;
    end
    if (inc_samp && sample_count_q != 16'hFFFF) begin
      sample_count_d = sample_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q    <= 16'd0;
      sample_count_q <= 16'd0;
    end else begin
      err_count_q    <= err_count_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign bus.err_count    = err_count_q;
  assign bus.sample_count = sample_count_q;
`else
  assign bus.err_count    = 16'd0;
  assign bus.sample_count = 16'd0;
`endif

endmodule

// File: tb/tb_random_checker.sv
// tb/tb_random_checker.sv - table-driven bench for random_checker
module tb_random_checker;

`ifdef RANDOM_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [3:0]  data;
    logic        exp_locked;
    logic        exp_err;
    logic [15:0] exp_ec;
    logic [15:0] exp_sc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  random_checker_if bus ();

  random_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name, input logic el, input logic ee,
                           input logic [15:0] ec, input logic [15:0] sc);
    logic [15:0] rec, rsc;
    rec = STATS ? ec : 16'd0;
    rsc = STATS ? sc : 16'd0;
    checks++;
    if (bus.locked !== el || bus.err_pulse !== ee ||
        bus.err_count !== rec || bus.sample_count !== rsc) begin
      errors++;
      $display("FAIL %s: got locked=%b err=%b ec=%0d sc=%0d, want locked=%b err=%b ec=%0d sc=%0d",
               name, bus.locked, bus.err_pulse, bus.err_count, bus.sample_count,
               el, ee, rec, rsc);
    end
  endtask

  task automatic step(input logic v, input logic [3:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, 4'b0011, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[2]  = '{1'b1, 4'b0101, 1'b0, 1'b0, 16'd0, 16'd0};
    vecs[3]  = '{1'b1, 4'b1110, 1'b1, 1'b0, 16'd0, 16'd0};
    vecs[4]  = '{1'b1, 4'b0010, 1'b1, 1'b0, 16'd0, 16'd1};
    vecs[5]  = '{1'b1, 4'b0111, 1'b1, 1'b1, 16'd1, 16'd2};
    vecs[6]  = '{1'b1, 4'b1011, 1'b1, 1'b0, 16'd1, 16'd3};
    vecs[7]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 16'd1, 16'd3};
    vecs[8]  = '{1'b1, 4'b1100, 1'b1, 1'b0, 16'd1, 16'd4};
    vecs[9]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 16'd2, 16'd5};
    vecs[10] = '{1'b1, 4'b1111, 1'b1, 1'b1, 16'd3, 16'd6};
    vecs[11] = '{1'b1, 4'b0001, 1'b0, 1'b1, 16'd4, 16'd7};
    vecs[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[13] = '{1'b1, 4'b0000, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[16] = '{1'b1, 4'b0001, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[17] = '{1'b0, 4'b0110, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[18] = '{1'b0, 4'b1111, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[19] = '{1'b1, 4'b0011, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[20] = '{1'b1, 4'b0101, 1'b0, 1'b0, 16'd4, 16'd7};
    vecs[21] = '{1'b1, 4'b1110, 1'b1, 1'b0, 16'd4, 16'd7};
    vecs[22] = '{1'b1, 4'b0010, 1'b1, 1'b0, 16'd4, 16'd8};
    vecs[23] = '{1'b1, 4'b0000, 1'b1, 1'b1, 16'd5, 16'd9};

    bus.in_valid = 1'b0;
    bus.in_data  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].valid, vecs[i].data);
      check_out($sformatf("vec%0d", i), vecs[i].exp_locked, vecs[i].exp_err,
                vecs[i].exp_ec, vecs[i].exp_sc);
    end

    // Asynchronous reset between edges while locked with an error pulse high.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Relock after reset needs a full run starting at the first edge.
    step(1'b1, 4'b1011);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b0100);
    check_out("relock_partial", 1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 4'b1101);
    check_out("relock_full", 1'b1, 1'b0, 16'd0, 16'd0);

    // A mismatch in HUNT restarts the run from the offending sample.
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0110);
    step(1'b1, 4'b1011);
    step(1'b1, 4'b1100);
    check_out("reseed_partial", 1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 4'b0100);
    check_out("reseed_lock", 1'b1, 1'b0, 16'd0, 16'd0);
    step(1'b1, 4'b1101);
    check_out("reseed_track", 1'b1, 1'b0, 16'd0, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/random_checker.md
RANDOM_CHECKER -- requirements
Module: random_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4, meaning consecutive correctly predicted samples (seed included) needed to declare lock; legal range 2..15.
REQ-002 Parameter LOSS_CNT, default 3, meaning consecutive mismatches while locked that drop lock; legal range 1..15.
REQ-003 Port clk  input  1  rising-edge clock, the only clock.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  in_data carries one generator sample this cycle.
REQ-006 Port in_data  input  4  sample from the 4-bit random generator.
REQ-007 Port locked  output  1  checker is synchronised to the sequence.
REQ-008 Port err_pulse  output  1  one-cycle flag for a mismatching sample while locked.
REQ-009 Port err_count  output  16  saturating mismatch count.
REQ-010 Port sample_count  output  16  saturating count of samples checked while locked.

Function
REQ-011 Predictor next(c) SHALL be: n[0]=c[0]^c[3]^c[2]; n[1]=c[1]^c[0]; n[2]=c[2]^c[1]; n[3]=c[3]^c[2].
REQ-012 Only cycles with in_valid=1 SHALL be processed; with in_valid=0, all state holds and err_pulse=0.
REQ-013 FSM states SHALL be HUNT and LOCKED; reset state is HUNT.
REQ-014 HUNT: in_data=4'b0000 SHALL be rejected (lock-up value): match_run cleared, no seed stored.
REQ-015 HUNT: with no seed, a nonzero sample SHALL become the seed and set match_run=1.
REQ-016 HUNT: with a seed, a sample equal to next(seed) SHALL increment match_run and become the new seed; otherwise it SHALL reseed with match_run=1, or clear per REQ-014 if zero.
REQ-017 When match_run reaches LOCK_CNT, the FSM SHALL enter LOCKED at that edge; expected=next(in_data); locked=1 from the following cycle.
REQ-018 LOCKED: each valid sample SHALL be compared to expected, and expected SHALL then advance to next(expected), never to next(in_data).
REQ-019 LOCKED match: miss_run cleared, sample_count incremented.
REQ-020 LOCKED mismatch: err_pulse=1 for exactly the cycle after the sampling edge; err_count and sample_count incremented; miss_run incremented.
REQ-021 When miss_run reaches LOSS_CNT, the FSM SHALL return to HUNT at that edge, clearing seed, match_run and miss_run; locked=0 the following cycle; err_pulse still fires for that sample.
REQ-022 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-023 Counters SHALL persist across lock loss and clear only on reset.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: HUNT, locked=0, err_pulse=0, err_count=0, sample_count=0, seed invalid, match_run=0, miss_run=0, expected=4'b0000.
REQ-025 Reset mid-run SHALL discard lock immediately; after release, relock SHALL require a full LOCK_CNT run.
REQ-026 The first rising edge with rst_n=1 SHALL process in_valid normally.

Configuration
REQ-027 Macro RANDOM_CHECKER_STATS_EN defined: err_count and sample_count SHALL behave per REQ-019 to REQ-023.
REQ-028 Macro undefined: err_count and sample_count SHALL be held at 0, with no counter registers; locked and err_pulse are unaffected.

Verification
REQ-029 Lock: reset, then valid 0001,0011,0101,1110 -> locked=1 the cycle after 1110; err_count=0.
REQ-030 Track: after REQ-029, send 0010 -> no err_pulse; sample_count=1 (STATS_EN).
REQ-031 Single error: locked, expected 0010, send 0111, then the correct sequence resumes -> one err_pulse, err_count=1, locked stays 1, miss_run clears on the next match.
REQ-032 Loss: locked, send three consecutive wrong samples with LOSS_CNT=3 -> three err_pulses, err_count=3, locked=0 after the third.
REQ-033 Zero/gaps: in HUNT, send 0000 repeatedly -> never locks; then 0001,(in_valid=0 two cycles),0011,0101,1110 -> locks.
REQ-034 Reset: assert rst_n=0 mid-LOCKED asynchronously, between clock edges -> locked, err_pulse and counters become 0 without waiting for a clock edge.
